// File: rtl/target_box_overlay_if.sv
// rtl/target_box_overlay_if.sv - pixel pack bundle {clk, hsync, vsync, de, r, g, b, x, y}
interface target_box_overlay_if #(
    parameter int H_ACT = 1280,
    parameter int V_ACT = 720
);
    localparam int XW = $clog2(H_ACT);
    localparam int YW = $clog2(V_ACT);
    localparam int PW = 28 + XW + YW;

    logic [PW-1:0] pack;

    modport master (output pack);
    modport slave  (input  pack);
endinterface

// File: rtl/target_box_overlay.sv
// rtl/target_box_overlay.sv - per-frame RGB target bounding box with outline overlay
module target_box_overlay #(
    parameter int          H_ACT     = 1280,
    parameter int          V_ACT     = 720,
    parameter logic [7:0]  R_MIN     = 8'd200,
    parameter logic [7:0]  G_MAX     = 8'd80,
    parameter logic [7:0]  B_MAX     = 8'd80,
    parameter int          MIN_HITS  = 16,
    parameter int          LINE_W    = 2,
    parameter logic [23:0] BOX_COLOR = 24'h00FF00,
    localparam int         XW        = $clog2(H_ACT),
    localparam int         YW        = $clog2(V_ACT)
) (
    input  logic                        main_clk,
    input  logic                        rstn,
    target_box_overlay_if.slave         i_pack,
    input  logic                        en,
    target_box_overlay_if.master        o_pack,
    output logic                        box_valid,
    output logic [XW-1:0]               box_x0,
    output logic [YW-1:0]               box_y0,
    output logic [XW-1:0]               box_x1,
    output logic [YW-1:0]               box_y1,
    output logic [19:0]                 hit_cnt
);
    localparam logic [XW:0] LW_X = (XW+1)'(LINE_W);
    localparam logic [YW:0] LW_Y = (YW+1)'(LINE_W);

    typedef enum logic [1:0] {S_WAIT, S_ACCUM, S_COMMIT} state_t;
    state_t state_q, state_d;

    logic          unused_clk, hs_in, vs_in, de_in;
    logic [7:0]    r_in, g_in, b_in;
    logic [XW-1:0] x_in;
    logic [YW-1:0] y_in;
    assign {unused_clk, hs_in, vs_in, de_in, r_in, g_in, b_in, x_in, y_in} = i_pack.pack;

    logic          s1_hs_q, s1_vs_q, s1_de_q, s1_en_q, s1_hit_q, vs_prev_q;
    logic [23:0]   s1_rgb_q;
    logic [XW-1:0] s1_x_q;
    logic [YW-1:0] s1_y_q;
    logic          s2_hs_q, s2_vs_q, s2_de_q;
    logic [23:0]   s2_rgb_q;
    logic [XW-1:0] s2_x_q;
    logic [YW-1:0] s2_y_q;

    logic [XW-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
    logic [YW-1:0] ymin_q, ymin_d, ymax_q, ymax_d;
    logic [19:0]   cnt_q, cnt_d, hit_cnt_q, hit_cnt_d;
    logic          box_valid_q, box_valid_d;
    logic [XW-1:0] box_x0_q, box_x0_d, box_x1_q, box_x1_d;
    logic [YW-1:0] box_y0_q, box_y0_d, box_y1_q, box_y1_d;

    logic fs, border, in_box, on_edge;
    assign fs = s1_vs_q & ~vs_prev_q;

    // Extra bit on the sums keeps boxes touching the last column/row from wrapping.
    assign in_box  = (s1_x_q >= box_x0_q) && (s1_x_q <= box_x1_q) &&
                     (s1_y_q >= box_y0_q) && (s1_y_q <= box_y1_q);
    assign on_edge = ({1'b0, s1_x_q} < {1'b0, box_x0_q} + LW_X) ||
                     ({1'b0, s1_x_q} + LW_X > {1'b0, box_x1_q}) ||
                     ({1'b0, s1_y_q} < {1'b0, box_y0_q} + LW_Y) ||
                     ({1'b0, s1_y_q} + LW_Y > {1'b0, box_y1_q});
    assign border  = s1_en_q && box_valid_q && s1_de_q && in_box && on_edge;

    always_ff @(posedge main_clk or negedge rstn) begin
        if (!rstn) begin
            s1_hs_q <= 1'b0; s1_vs_q <= 1'b0; s1_de_q <= 1'b0; s1_en_q <= 1'b0;
            s1_hit_q <= 1'b0; vs_prev_q <= 1'b0; s1_rgb_q <= '0; s1_x_q <= '0; s1_y_q <= '0;
            s2_hs_q <= 1'b0; s2_vs_q <= 1'b0; s2_de_q <= 1'b0;
            s2_rgb_q <= '0; s2_x_q <= '0; s2_y_q <= '0;
            state_q <= S_WAIT;
            xmin_q <= '0; xmax_q <= '0; ymin_q <= '0; ymax_q <= '0; cnt_q <= '0;
            hit_cnt_q <= '0; box_valid_q <= 1'b0;
            box_x0_q <= '0; box_x1_q <= '0; box_y0_q <= '0; box_y1_q <= '0;
        end else begin
            s1_hs_q   <= hs_in;
            s1_vs_q   <= vs_in;
            s1_de_q   <= de_in;
            s1_en_q   <= en;
            s1_hit_q  <= de_in && (r_in >= R_MIN) && (g_in <= G_MAX) && (b_in <= B_MAX);
            s1_rgb_q  <= {r_in, g_in, b_in};
            s1_x_q    <= x_in;
            s1_y_q    <= y_in;
            vs_prev_q <= s1_vs_q;
            s2_hs_q   <= s1_hs_q;
            s2_vs_q   <= s1_vs_q;
            s2_de_q   <= s1_de_q;
            s2_rgb_q  <= border ? BOX_COLOR : s1_rgb_q;
            s2_x_q    <= s1_x_q;
            s2_y_q    <= s1_y_q;
            state_q   <= state_d;
            xmin_q <= xmin_d; xmax_q <= xmax_d; ymin_q <= ymin_d; ymax_q <= ymax_d;
            cnt_q <= cnt_d; hit_cnt_q <= hit_cnt_d; box_valid_q <= box_valid_d;
            box_x0_q <= box_x0_d; box_x1_q <= box_x1_d; box_y0_q <= box_y0_d; box_y1_q <= box_y1_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        xmin_d      = xmin_q;
        xmax_d      = xmax_q;
        ymin_d      = ymin_q;
        ymax_d      = ymax_q;
        cnt_d       = cnt_q;
        hit_cnt_d   = hit_cnt_q;
        box_valid_d = box_valid_q;
        box_x0_d    = box_x0_q;
        box_x1_d    = box_x1_q;
        box_y0_d    = box_y0_q;
        box_y1_d    = box_y1_q;
        case (state_q)
            S_WAIT: begin
                xmin_d = XW'(H_ACT - 1); ymin_d = YW'(V_ACT - 1);
                xmax_d = '0; ymax_d = '0; cnt_d = '0;
                if (fs) state_d = S_ACCUM;
            end
            S_ACCUM: begin
                if (fs) begin
                    state_d = S_COMMIT;
                end else if (s1_hit_q) begin
                    if (s1_x_q < xmin_q) xmin_d = s1_x_q;
                    if (s1_x_q > xmax_q) xmax_d = s1_x_q;
                    if (s1_y_q < ymin_q) ymin_d = s1_y_q;
                    if (s1_y_q > ymax_q) ymax_d = s1_y_q;
                    if (cnt_q != 20'hFFFFF) cnt_d = cnt_q + 20'd1;
                end
            end
            S_COMMIT: begin
                box_valid_d = (cnt_q >= 20'(MIN_HITS));
                hit_cnt_d   = cnt_q;
                if (cnt_q >= 20'(MIN_HITS)) begin
                    box_x0_d = xmin_q; box_y0_d = ymin_q;
                    box_x1_d = xmax_q; box_y1_d = ymax_q;
                end
                xmin_d = XW'(H_ACT - 1); ymin_d = YW'(V_ACT - 1);
                xmax_d = '0; ymax_d = '0; cnt_d = '0;
                state_d = S_ACCUM;
            end
            default: state_d = S_WAIT;
        endcase
    end

    assign o_pack.pack = {main_clk, s2_hs_q, s2_vs_q, s2_de_q, s2_rgb_q, s2_x_q, s2_y_q};
    assign box_valid   = box_valid_q;
    assign box_x0      = box_x0_q;
    assign box_y0      = box_y0_q;
    assign box_x1      = box_x1_q;
    assign box_y1      = box_y1_q;
    assign hit_cnt     = hit_cnt_q;
endmodule
